// File: rtl/alu_reservation_station_if.sv
// Bundle between the dispatcher, the two result broadcast buses, and the issue port feeding the ALU stage.
// master = surrounding pipeline, slave = the reservation station.
interface alu_reservation_station_if #(
  parameter int CSU_SIZE_BITS = 4,
  parameter int RS_SIZE_BITS  = 3
);
  logic                     rdy_in;
  logic                     flush_pipline;

  logic                     dispatch_valid;
  logic [CSU_SIZE_BITS-1:0] dispatch_ins_id;
  logic [6:0]               dispatch_opcode;
  logic [2:0]               dispatch_funct3;
  logic [6:0]               dispatch_funct7;
  logic [31:0]              dispatch_imm;
  logic [31:0]              dispatch_PC;
  logic [5:0]               dispatch_shamt;
  logic                     dispatch_is_compressed;
  logic                     dispatch_rs1_rdy;
  logic                     dispatch_rs2_rdy;
  logic [31:0]              dispatch_rs1_val;
  logic [31:0]              dispatch_rs2_val;
  logic [CSU_SIZE_BITS-1:0] dispatch_rs1_tag;
  logic [CSU_SIZE_BITS-1:0] dispatch_rs2_tag;

  logic                     alu_cdb_valid;
  logic [CSU_SIZE_BITS-1:0] alu_cdb_id;
  logic [31:0]              alu_cdb_val;
  logic                     mem_cdb_valid;
  logic [CSU_SIZE_BITS-1:0] mem_cdb_id;
  logic [31:0]              mem_cdb_val;

  logic                     rs_full;
  logic [RS_SIZE_BITS:0]    rs_count;
  logic                     have_ins;
  logic [CSU_SIZE_BITS-1:0] ins_id;
  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [31:0]              imm_val;
  logic [5:0]               shamt_val;
  logic [31:0]              request_PC;
  logic                     is_compressed_ins;
  logic [31:0]              rs1_val;
  logic [31:0]              rs2_val;

  modport master (
    output rdy_in, flush_pipline,
    output dispatch_valid, dispatch_ins_id, dispatch_opcode, dispatch_funct3, dispatch_funct7,
    output dispatch_imm, dispatch_PC, dispatch_shamt, dispatch_is_compressed,
    output dispatch_rs1_rdy, dispatch_rs2_rdy, dispatch_rs1_val, dispatch_rs2_val,
    output dispatch_rs1_tag, dispatch_rs2_tag,
    output alu_cdb_valid, alu_cdb_id, alu_cdb_val, mem_cdb_valid, mem_cdb_id, mem_cdb_val,
    input  rs_full, rs_count, have_ins, ins_id, opcode, funct3, funct7, imm_val, shamt_val,
    input  request_PC, is_compressed_ins, rs1_val, rs2_val
  );

  modport slave (
    input  rdy_in, flush_pipline,
    input  dispatch_valid, dispatch_ins_id, dispatch_opcode, dispatch_funct3, dispatch_funct7,
    input  dispatch_imm, dispatch_PC, dispatch_shamt, dispatch_is_compressed,
    input  dispatch_rs1_rdy, dispatch_rs2_rdy, dispatch_rs1_val, dispatch_rs2_val,
    input  dispatch_rs1_tag, dispatch_rs2_tag,
    input  alu_cdb_valid, alu_cdb_id, alu_cdb_val, mem_cdb_valid, mem_cdb_id, mem_cdb_val,
    output rs_full, rs_count, have_ins, ins_id, opcode, funct3, funct7, imm_val, shamt_val,
    output request_PC, is_compressed_ins, rs1_val, rs2_val
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds ops until both operands arrive via the CDBs, issues one per cycle.
// Define ALU_RS_OLDEST_FIRST_EN for oldest-first issue via an age matrix; default issues lowest index first.
module alu_reservation_station #(
  parameter int CSU_SIZE_BITS = 4,
  parameter int RS_SIZE       = 8,
  parameter int RS_SIZE_BITS  = 3
) (
  input logic                      clk_in,
  input logic                      rst_in,
  alu_reservation_station_if.slave rs_bus
);

  typedef struct packed {
    logic [CSU_SIZE_BITS-1:0] ins_id;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [31:0]              imm;
    logic [31:0]              pc;
    logic [5:0]               shamt;
    logic                     is_compressed;
  } payload_t;

  typedef struct packed {
    logic                     rdy;
    logic [CSU_SIZE_BITS-1:0] tag;
    logic [31:0]              val;
  } operand_t;

  logic [RS_SIZE-1:0]      valid;
  payload_t                payload [RS_SIZE];
  operand_t                src1    [RS_SIZE];
  operand_t                src2    [RS_SIZE];

  logic [RS_SIZE-1:0]      eligible;
  logic [RS_SIZE_BITS:0]   count;
  logic                    full;
  logic                    do_dispatch;
  logic [RS_SIZE_BITS-1:0] free_idx;
  logic                    issue_any;
  logic [RS_SIZE_BITS-1:0] issue_idx;
  payload_t                new_payload;
  operand_t                new_src1;
  operand_t                new_src2;

  // ALU bus wins when both buses carry the tag in the same cycle.
  function automatic operand_t wake(input operand_t op,
                                    input logic a_valid, input logic [CSU_SIZE_BITS-1:0] a_id,
                                    input logic [31:0] a_val,
                                    input logic m_valid, input logic [CSU_SIZE_BITS-1:0] m_id,
                                    input logic [31:0] m_val);
    operand_t res;
    res = op;
    if (!op.rdy) begin
      if (a_valid && a_id == op.tag) begin
        res.rdy = 1'b1;
        res.val = a_val;
      end else if (m_valid && m_id == op.tag) begin
        res.rdy = 1'b1;
        res.val = m_val;
      end
    end
    return res;
  endfunction

  always_comb begin
    count    = '0;
    eligible = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      count       = count + (RS_SIZE_BITS+1)'(valid[i]);
      eligible[i] = valid[i] & src1[i].rdy & src2[i].rdy;
    end
  end

  assign full            = &valid;
  assign do_dispatch     = rs_bus.dispatch_valid & ~full;
  assign rs_bus.rs_count = count;
  assign rs_bus.rs_full  = full;

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = RS_SIZE_BITS'(i);
    end
  end

  // Operands missing at dispatch may still be caught from this cycle's broadcasts.
  always_comb begin
    new_payload = '{ins_id:        rs_bus.dispatch_ins_id,
                    opcode:        rs_bus.dispatch_opcode,
                    funct3:        rs_bus.dispatch_funct3,
                    funct7:        rs_bus.dispatch_funct7,
                    imm:           rs_bus.dispatch_imm,
                    pc:            rs_bus.dispatch_PC,
                    shamt:         rs_bus.dispatch_shamt,
                    is_compressed: rs_bus.dispatch_is_compressed};
    new_src1 = wake('{rdy: rs_bus.dispatch_rs1_rdy, tag: rs_bus.dispatch_rs1_tag,
                      val: rs_bus.dispatch_rs1_val},
                    rs_bus.alu_cdb_valid, rs_bus.alu_cdb_id, rs_bus.alu_cdb_val,
                    rs_bus.mem_cdb_valid, rs_bus.mem_cdb_id, rs_bus.mem_cdb_val);
    new_src2 = wake('{rdy: rs_bus.dispatch_rs2_rdy, tag: rs_bus.dispatch_rs2_tag,
                      val: rs_bus.dispatch_rs2_val},
                    rs_bus.alu_cdb_valid, rs_bus.alu_cdb_id, rs_bus.alu_cdb_val,
                    rs_bus.mem_cdb_valid, rs_bus.mem_cdb_id, rs_bus.mem_cdb_val);
  end

`ifdef ALU_RS_OLDEST_FIRST_EN
  // age[j][i] set means entry j was dispatched before entry i.
  logic [RS_SIZE-1:0] age      [RS_SIZE];
  logic [RS_SIZE-1:0] age_next [RS_SIZE];
  logic [RS_SIZE-1:0] has_older;

  always_comb begin
    has_older = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (eligible[j] && age[j][i]) has_older[i] = 1'b1;
      end
    end
  end

  always_comb begin
    issue_any = |eligible;
    issue_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (eligible[i] && !has_older[i]) issue_idx = RS_SIZE_BITS'(i);
    end
  end

  always_comb begin
    age_next = age;
    if (issue_any) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        age_next[issue_idx][j] = 1'b0;
        age_next[j][issue_idx] = 1'b0;
      end
    end
    if (do_dispatch) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        age_next[free_idx][j] = 1'b0;
        age_next[j][free_idx] = valid[j] & ~(issue_any & (issue_idx == RS_SIZE_BITS'(j)));
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      age <= '{default: '0};
    end else if (rs_bus.rdy_in) begin
      if (rs_bus.flush_pipline) age <= '{default: '0};
      else                      age <= age_next;
    end
  end
`else
  always_comb begin
    issue_any = |eligible;
    issue_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (eligible[i]) issue_idx = RS_SIZE_BITS'(i);
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid                    <= '0;
      rs_bus.have_ins          <= 1'b0;
      rs_bus.ins_id            <= '0;
      rs_bus.opcode            <= '0;
      rs_bus.funct3            <= '0;
      rs_bus.funct7            <= '0;
      rs_bus.imm_val           <= '0;
      rs_bus.shamt_val         <= '0;
      rs_bus.request_PC        <= '0;
      rs_bus.is_compressed_ins <= 1'b0;
      rs_bus.rs1_val           <= '0;
      rs_bus.rs2_val           <= '0;
    end else if (rs_bus.rdy_in) begin
      if (rs_bus.flush_pipline) begin
        valid           <= '0;
        rs_bus.have_ins <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (valid[i]) begin
            src1[i] <= wake(src1[i], rs_bus.alu_cdb_valid, rs_bus.alu_cdb_id, rs_bus.alu_cdb_val,
                            rs_bus.mem_cdb_valid, rs_bus.mem_cdb_id, rs_bus.mem_cdb_val);
            src2[i] <= wake(src2[i], rs_bus.alu_cdb_valid, rs_bus.alu_cdb_id, rs_bus.alu_cdb_val,
                            rs_bus.mem_cdb_valid, rs_bus.mem_cdb_id, rs_bus.mem_cdb_val);
          end
        end

        // Issue uses pre-edge state, so the freed slot never collides with the dispatch slot.
        if (issue_any) begin
          valid[issue_idx]         <= 1'b0;
          rs_bus.have_ins          <= 1'b1;
          rs_bus.ins_id            <= payload[issue_idx].ins_id;
          rs_bus.opcode            <= payload[issue_idx].opcode;
          rs_bus.funct3            <= payload[issue_idx].funct3;
          rs_bus.funct7            <= payload[issue_idx].funct7;
          rs_bus.imm_val           <= payload[issue_idx].imm;
          rs_bus.shamt_val         <= payload[issue_idx].shamt;
          rs_bus.request_PC        <= payload[issue_idx].pc;
          rs_bus.is_compressed_ins <= payload[issue_idx].is_compressed;
          rs_bus.rs1_val           <= src1[issue_idx].val;
          rs_bus.rs2_val           <= src2[issue_idx].val;
        end else begin
          rs_bus.have_ins <= 1'b0;
        end

        if (do_dispatch) begin
          valid[free_idx]   <= 1'b1;
          payload[free_idx] <= new_payload;
          src1[free_idx]    <= new_src1;
          src2[free_idx]    <= new_src2;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: stimulus pushes expected issues, a negedge monitor checks them.
module tb_alu_reservation_station;
  localparam int CSU_SIZE_BITS = 4;
  localparam int RS_SIZE       = 8;
  localparam int RS_SIZE_BITS  = 3;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_reservation_station_if #(.CSU_SIZE_BITS(CSU_SIZE_BITS), .RS_SIZE_BITS(RS_SIZE_BITS)) bus ();

  alu_reservation_station #(
    .CSU_SIZE_BITS(CSU_SIZE_BITS),
    .RS_SIZE(RS_SIZE),
    .RS_SIZE_BITS(RS_SIZE_BITS)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rs_bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.dispatch_valid = 1'b0;
    bus.alu_cdb_valid  = 1'b0;
    bus.mem_cdb_valid  = 1'b0;
    bus.flush_pipline  = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [3:0] id,
                                input logic r1_rdy, input logic [31:0] r1_val, input logic [3:0] r1_tag,
                                input logic r2_rdy, input logic [31:0] r2_val, input logic [3:0] r2_tag,
                                input logic [31:0] imm);
    bus.dispatch_valid         = 1'b1;
    bus.dispatch_ins_id        = id;
    bus.dispatch_opcode        = 7'h33;
    bus.dispatch_funct3        = id[2:0];
    bus.dispatch_funct7        = {id, 3'b000};
    bus.dispatch_imm           = imm;
    bus.dispatch_PC            = 32'h1000 + {26'd0, id, 2'b00};
    bus.dispatch_shamt         = {2'b00, id};
    bus.dispatch_is_compressed = id[0];
    bus.dispatch_rs1_rdy       = r1_rdy;
    bus.dispatch_rs1_val       = r1_val;
    bus.dispatch_rs1_tag       = r1_tag;
    bus.dispatch_rs2_rdy       = r2_rdy;
    bus.dispatch_rs2_val       = r2_val;
    bus.dispatch_rs2_tag       = r2_tag;
  endtask

  task automatic alu_bcast(input logic [3:0] id, input logic [31:0] val);
    bus.alu_cdb_valid = 1'b1;
    bus.alu_cdb_id    = id;
    bus.alu_cdb_val   = val;
  endtask

  task automatic mem_bcast(input logic [3:0] id, input logic [31:0] val);
    bus.mem_cdb_valid = 1'b1;
    bus.mem_cdb_id    = id;
    bus.mem_cdb_val   = val;
  endtask

  task automatic expect_issue(input logic [3:0] id, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input int at_cyc);
    exp_t e;
    e.id = id; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.cyc = at_cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: every issue strobe must match the oldest outstanding expectation, in that exact cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.have_ins) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_issue actual ins_id=%0d required no issue (cycle %0d)",
                 bus.ins_id, cyc);
      end else begin
        e = sb.pop_front();
        check_output("issue_cycle", 64'(cyc), 64'(e.cyc));
        check_output("ins_id", 64'(bus.ins_id), 64'(e.id));
        check_output("rs1_val", 64'(bus.rs1_val), 64'(e.rs1));
        check_output("rs2_val", 64'(bus.rs2_val), 64'(e.rs2));
        check_output("imm_val", 64'(bus.imm_val), 64'(e.imm));
        check_output("request_PC", 64'(bus.request_PC), 64'(32'h1000 + {26'd0, e.id, 2'b00}));
        check_output("decode_fields",
                     64'({bus.opcode, bus.funct3, bus.funct7, bus.shamt_val, bus.is_compressed_ins}),
                     64'({7'h33, e.id[2:0], e.id, 3'b000, 2'b00, e.id, e.id[0]}));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.rdy_in = 1'b1;
    bus.flush_pipline = 1'b0;
    bus.dispatch_valid = 1'b0;
    apply_stimulus(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
    bus.dispatch_valid = 1'b0;
    bus.alu_cdb_valid = 1'b0; bus.alu_cdb_id = '0; bus.alu_cdb_val = '0;
    bus.mem_cdb_valid = 1'b0; bus.mem_cdb_id = '0; bus.mem_cdb_val = '0;

    rst = 1'b1;
    idle(3);
    check_output("reset_have_ins", 64'(bus.have_ins), 64'd0);
    check_output("reset_rs_count", 64'(bus.rs_count), 64'd0);
    check_output("reset_rs_full", 64'(bus.rs_full), 64'd0);
    check_output("reset_payload", 64'({bus.ins_id, bus.rs1_val, bus.imm_val}), 64'd0);
    rst = 1'b0;
    tick();

    // ADDI with ready operand: issues two edges after dispatch is presented.
    apply_stimulus(4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 32'd7);
    expect_issue(4'd3, 32'd5, 32'd0, 32'd7, cyc + 2);
    idle(4);
    check_output("held_ins_id", 64'(bus.ins_id), 64'd3);
    check_output("held_have_ins", 64'(bus.have_ins), 64'd0);

    // ADD waiting on tag 6; a wrong-tag broadcast must not wake it.
    apply_stimulus(4'd2, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd6, 32'd0);
    tick();
    mem_bcast(4'd5, 32'hDEAD);
    tick();
    check_output("waiting_count", 64'(bus.rs_count), 64'd1);
    alu_bcast(4'd6, 32'h10);
    expect_issue(4'd2, 32'd1, 32'h10, 32'd0, cyc + 2);
    idle(4);

    // Same-cycle capture from each bus at dispatch.
    apply_stimulus(4'd7, 1'b0, 32'd0, 4'd4, 1'b1, 32'd3, 4'd0, 32'd0);
    alu_bcast(4'd4, 32'd9);
    expect_issue(4'd7, 32'd9, 32'd3, 32'd0, cyc + 2);
    idle(3);
    apply_stimulus(4'd8, 1'b1, 32'h20, 4'd0, 1'b0, 32'd0, 4'd9, 32'd0);
    mem_bcast(4'd9, 32'h55);
    expect_issue(4'd8, 32'h20, 32'h55, 32'd0, cyc + 2);
    idle(3);

    // Both buses carry the same id: ALU value is taken.
    apply_stimulus(4'd5, 1'b0, 32'd0, 4'd10, 1'b1, 32'd0, 4'd0, 32'd0);
    tick();
    alu_bcast(4'd10, 32'hA);
    mem_bcast(4'd10, 32'hB);
    expect_issue(4'd5, 32'hA, 32'd0, 32'd0, cyc + 2);
    idle(4);

    // Issue and dispatch on the same edge keep the count level, then fill to full.
    apply_stimulus(4'd1, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 32'd0);
    expect_issue(4'd1, 32'h11, 32'h22, 32'd0, cyc + 2);
    tick();
    check_output("count_before_swap", 64'(bus.rs_count), 64'd1);
    apply_stimulus(4'd14, 1'b0, 32'd0, 4'd15, 1'b0, 32'd0, 4'd15, 32'd0);
    tick();
    check_output("count_after_swap", 64'(bus.rs_count), 64'd1);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(4'(i), 1'b0, 32'd0, 4'd15, 1'b0, 32'd0, 4'd15, 32'd0);
      tick();
    end
    check_output("count_seven", 64'(bus.rs_count), 64'd7);
    check_output("not_full_seven", 64'(bus.rs_full), 64'd0);
    apply_stimulus(4'd6, 1'b0, 32'd0, 4'd15, 1'b0, 32'd0, 4'd15, 32'd0);
    tick();
    check_output("count_full", 64'(bus.rs_count), 64'd8);
    check_output("full_flag", 64'(bus.rs_full), 64'd1);
    apply_stimulus(4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'd0);
    tick();
    check_output("ninth_ignored", 64'(bus.rs_count), 64'd8);
    idle(2);
    bus.flush_pipline = 1'b1;
    alu_bcast(4'd15, 32'h99);
    tick();
    check_output("flush_count", 64'(bus.rs_count), 64'd0);
    check_output("flush_full", 64'(bus.rs_full), 64'd0);
    check_output("flush_have_ins", 64'(bus.have_ins), 64'd0);
    idle(3);

    // Stall: a ready op, a waiting op, CDB activity and a dispatch all frozen by rdy_in low.
    apply_stimulus(4'd13, 1'b1, 32'd0, 4'd0, 1'b0, 32'd0, 4'd11, 32'd0);
    tick();
    apply_stimulus(4'd6, 1'b1, 32'h21, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
    tick();
    bus.rdy_in = 1'b0;
    apply_stimulus(4'd12, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 32'd0);
    alu_bcast(4'd11, 32'h77);
    tick();
    check_output("stall_have_ins", 64'(bus.have_ins), 64'd0);
    check_output("stall_count", 64'(bus.rs_count), 64'd2);
    mem_bcast(4'd11, 32'h78);
    tick();
    tick();
    check_output("stall_count_late", 64'(bus.rs_count), 64'd2);
    check_output("stall_ins_id", 64'(bus.ins_id), 64'd1);
    bus.rdy_in = 1'b1;
    expect_issue(4'd6, 32'h21, 32'd0, 32'd0, cyc + 1);
    idle(4);
    check_output("waiter_not_woken", 64'(bus.rs_count), 64'd1);
    bus.flush_pipline = 1'b1;
    tick();
    check_output("flush2_count", 64'(bus.rs_count), 64'd0);
    idle(2);

    // Selection order: id=1 sits in slot 5, id=2 lands in slot 0 later; both become ready together.
    apply_stimulus(4'd10, 1'b0, 32'd0, 4'd13, 1'b1, 32'd0, 4'd0, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(4'(11 + i), 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0, 32'd0);
      tick();
    end
    apply_stimulus(4'd1, 1'b0, 32'd0, 4'd12, 1'b1, 32'h100, 4'd0, 32'd0);
    tick();
    alu_bcast(4'd13, 32'h33);
    expect_issue(4'd10, 32'h33, 32'd0, 32'd0, cyc + 2);
    tick();
    tick();
    apply_stimulus(4'd2, 1'b1, 32'h200, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
    alu_bcast(4'd12, 32'h44);
`ifdef ALU_RS_OLDEST_FIRST_EN
    expect_issue(4'd1, 32'h44, 32'h100, 32'd0, cyc + 2);
    expect_issue(4'd2, 32'h200, 32'd0, 32'd0, cyc + 3);
`else
    expect_issue(4'd2, 32'h200, 32'd0, 32'd0, cyc + 2);
    expect_issue(4'd1, 32'h44, 32'h100, 32'd0, cyc + 3);
`endif
    idle(4);
    check_output("order_leftover", 64'(bus.rs_count), 64'd4);
    bus.flush_pipline = 1'b1;
    idle(3);

    check_output("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
